mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port of axi_interface between the instruction-fetch side (F stage) and the load/store side (M stage) of the CPU core.
- Replaces the ad-hoc inst_miss select in mycpu_top.
- Holds a fetched instruction until the pipeline advances, so the fetch is never repeated while a load/store runs.
- Applies the confreg address remap and suppresses completion of accesses cancelled by an exception flush.

Parameters:
- REMAP_FROM, 16'hbfaf, upper data-address half that is rewritten.
- REMAP_TO, 16'h1faf, replacement upper half.

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous reset, active-high (the core's internal resetn, i.e. ~aresetn).
- i_req  in  1  F stage wants an instruction at i_addr.
- i_addr  in  32  physical fetch address.
- if_advance  in  1  pipeline consumes the held instruction this cycle (F not stalled).
- i_valid  out  1  i_rdata holds a valid instruction for i_addr.
- i_rdata  out  32  held instruction word.
- d_req  in  1  M stage load/store enable (memenM).
- d_write  in  1  1 = store.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_sel  in  4  byte strobes.
- d_addr  in  32  physical data address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data, valid with d_ready.
- flush  in  1  exception in M (|excepttypeM).
- stall_if  out  1  = i_req & ~i_valid.
- stall_mem  out  1  = d_req & ~d_ready.
- mem_access  out  1  request to axi_interface.
- mem_write  out  1  write.
- mem_a  out  32  address.
- mem_size  out  2  size.
- mem_sel  out  4  strobes.
- mem_st_data  out  32  write data.
- mem_ready  in  1  axi_interface completion pulse.
- mem_data  in  32  read data, valid with mem_ready.

Behaviour:
- Reset values: state IDLE, all mem_* outputs 0, i_valid 0, i_rdata 0, d_ready 0, d_rdata 0, cancel flag 0.
- Reset mid-transaction returns to IDLE immediately; a later mem_ready is ignored.
- States:
  - IDLE: accept a new request.
  - D_BUSY: data access outstanding.
  - I_BUSY: fetch outstanding.
- IDLE arbitration:
  - If d_req & ~flush & ~d_done: go to D_BUSY. Data has priority because the M instruction is older.
  - Else if i_req & ~i_valid: go to I_BUSY.
  - Else stay in IDLE.
- Request latching (registered): on entering a BUSY state, latch address, size, sel, write and wdata into the mem_* registers.
  - Fetch: mem_size=2'b10, mem_sel=4'b1111, mem_write=0.
  - Data: if d_addr[31:16]==REMAP_FROM, mem_a={REMAP_TO,d_addr[15:0]}; otherwise d_addr.
- mem_access = (state != IDLE).
  - Fields are stable for the whole BUSY period.
  - Request to mem_access latency is 1 cycle.
- Completion (mem_ready in a BUSY state): next state is IDLE, and mem_access drops the cycle after. A minimum one-cycle IDLE gap occurs between transactions.
  - D_BUSY & ~cancel: d_ready=1 combinationally that cycle, d_rdata=mem_data. Set d_done, which blocks re-issue of the same access while d_req stays high for one cycle.
  - d_done clears when d_req is low or one cycle after d_ready.
  - I_BUSY & ~cancel: i_rdata<=mem_data, i_valid<=1 next cycle.
- Instruction hold: i_valid stays 1 until if_advance.
  - On if_advance, i_valid<=0 and a new fetch may start the following IDLE cycle.
  - if_advance with i_valid=0 has no effect.
- Flush:
  - In IDLE, flush blocks data issue that cycle.
  - In a BUSY state, flush sets cancel. The AXI transaction still completes, but its mem_ready produces no d_ready and no i_valid; cancel clears on return to IDLE.
  - A flush also clears i_valid, because the held instruction is on the wrong path.
- Simultaneous if_advance and flush: flush wins, and i_valid=0.
- mem_ready in IDLE is ignored.

Decomposition:
- Shared package (cpu_defs) holds:
  - State encoding: IDLE/I_BUSY/D_BUSY.
  - SIZE_BYTE/HALF/WORD constants.
  - Remap constants.
- No sub-module is needed. The address remap is a single function placed in the package.

Test Plan:
- Fetch only: i_req=1, i_addr=32'hbfc00000, mem_ready after 3 cycles with mem_data=32'h3c1d8000.
  - Expect mem_access 1 cycle after i_req, held 3 cycles.
  - Then i_valid=1, i_rdata=32'h3c1d8000, held until if_advance.
- Conflict: i_req and d_req both rise in IDLE, d_addr=32'h80001000, load word.
  - Expect the data access is issued first and d_ready pulses once.
  - Fetch is issued after one IDLE cycle.
- Remap: store to 32'hbfaf8000, d_sel=4'b0001, d_size=00.
  - Expect mem_a=32'h1faf8000, mem_write=1, mem_sel=4'b0001, mem_size=00.
- Flush in D_BUSY: flush pulses mid-load.
  - Expect the mem_ready pulse gives no d_ready, state returns to IDLE, and no reissue.
- Hold: i_valid=1, then a store in M, then if_advance.
  - Expect no second fetch to the same address.
  - Next fetch starts only after if_advance.
- Reset in I_BUSY: then mem_ready arrives.
  - Expect all outputs 0 and i_valid stays 0.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared state encoding, access sizes and confreg remap for the memory port arbiter.
package cpu_defs;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [15:0] REMAP_FROM_DEF = 16'hbfaf;
  localparam logic [15:0] REMAP_TO_DEF = 16'h1faf;
  function automatic logic [31:0] remap_addr(input logic [31:0] a, input logic [15:0] from, input logic [15:0] to);
    return (a[31:16] == from) ? {to, a[15:0]} : a;
  endfunction
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, holding fetched words until consumed.
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter logic [15:0] REMAP_FROM = REMAP_FROM_DEF,
  parameter logic [15:0] REMAP_TO = REMAP_TO_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        if_advance,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_access,
  output logic        mem_write,
  output logic [31:0] mem_a,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);
  state_t state, state_n;
  logic cancel, d_done, busy, issue_d, issue_i, fetch_done;
  always_comb begin
    busy = state != IDLE;
    issue_d = (state == IDLE) & d_req & ~flush & ~d_done;
    issue_i = (state == IDLE) & ~issue_d & i_req & ~i_valid;
    state_n = issue_d ? D_BUSY : issue_i ? I_BUSY : (busy & mem_ready) ? IDLE : state;
    d_ready = (state == D_BUSY) & mem_ready & ~cancel;
    d_rdata = d_ready ? mem_data : 32'h0;
    fetch_done = (state == I_BUSY) & mem_ready & ~cancel;
    mem_access = busy;
    stall_if = i_req & ~i_valid;
    stall_mem = d_req & ~d_ready;
  end
  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else state <= state_n;
  end
  // A flushed transaction still has to drain on the bus; cancel only masks its completion.
  always_ff @(posedge clk) begin
    if (resetn) begin
      cancel <= 1'b0;
      d_done <= 1'b0;
      i_valid <= 1'b0;
      i_rdata <= 32'h0;
      mem_write <= 1'b0;
      mem_a <= 32'h0;
      mem_size <= 2'b00;
      mem_sel <= 4'h0;
      mem_st_data <= 32'h0;
    end else begin
      cancel <= busy & ~mem_ready & (cancel | flush);
      d_done <= d_ready;
      i_valid <= flush ? 1'b0 : fetch_done ? 1'b1 : if_advance ? 1'b0 : i_valid;
      if (fetch_done) i_rdata <= mem_data;
      if (issue_d) begin
        mem_write <= d_write;
        mem_a <= remap_addr(d_addr, REMAP_FROM, REMAP_TO);
        mem_size <= d_size;
        mem_sel <= d_sel;
        mem_st_data <= d_wdata;
      end else if (issue_i) begin
        mem_write <= 1'b0;
        mem_a <= i_addr;
        mem_size <= SIZE_WORD;
        mem_sel <= 4'hf;
        mem_st_data <= 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests for the memory port arbiter.
module tb_mem_port_arbiter;
  logic clk = 0, resetn, i_req, if_advance, d_req, d_write, flush, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_data;
  logic [1:0] d_size;
  logic [3:0] d_sel;
  logic i_valid, d_ready, stall_if, stall_mem, mem_access, mem_write;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_st_data;
  logic [1:0] mem_size;
  logic [3:0] mem_sel;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn), .i_req(i_req), .i_addr(i_addr), .if_advance(if_advance),
    .i_valid(i_valid), .i_rdata(i_rdata), .d_req(d_req), .d_write(d_write), .d_size(d_size),
    .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .flush(flush), .stall_if(stall_if), .stall_mem(stall_mem), .mem_access(mem_access),
    .mem_write(mem_write), .mem_a(mem_a), .mem_size(mem_size), .mem_sel(mem_sel),
    .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data)
  );
  task tick;
    @(negedge clk);
  endtask
  task test_reset;
    resetn = 1; tick; tick; #1;
    vecs++; if (mem_access !== 1'b0) begin errs++; $display("FAIL reset_access got %0h exp 0", mem_access); end
    vecs++; if ({i_valid, d_ready, mem_write} !== 3'b000) begin errs++; $display("FAIL reset_flags got %0h exp 0", {i_valid, d_ready, mem_write}); end
    vecs++; if ({mem_a, i_rdata, d_rdata} !== 96'h0) begin errs++; $display("FAIL reset_data got %h exp 0", {mem_a, i_rdata, d_rdata}); end
    vecs++; if ({mem_size, mem_sel, mem_st_data} !== 38'h0) begin errs++; $display("FAIL reset_fields got %h exp 0", {mem_size, mem_sel, mem_st_data}); end
    resetn = 0;
  endtask
  task test_fetch;
    tick; i_req = 1; i_addr = 32'hbfc00000; #1;
    vecs++; if (mem_access !== 1'b0 || stall_if !== 1'b1) begin errs++; $display("FAIL fetch_latency got access=%0h stall_if=%0h exp 0 1", mem_access, stall_if); end
    tick; #1;
    vecs++; if ({mem_access, mem_write, mem_size, mem_sel} !== {1'b1, 1'b0, 2'b10, 4'hf}) begin errs++; $display("FAIL fetch_fields got %b exp 1010_1111", {mem_access, mem_write, mem_size, mem_sel}); end
    vecs++; if (mem_a !== 32'hbfc00000) begin errs++; $display("FAIL fetch_addr got %h exp bfc00000", mem_a); end
    tick; #1;
    vecs++; if (mem_access !== 1'b1 || i_valid !== 1'b0) begin errs++; $display("FAIL fetch_hold2 got access=%0h i_valid=%0h exp 1 0", mem_access, i_valid); end
    tick; mem_ready = 1; mem_data = 32'h3c1d8000; #1;
    vecs++; if (mem_access !== 1'b1 || i_valid !== 1'b0) begin errs++; $display("FAIL fetch_hold3 got access=%0h i_valid=%0h exp 1 0", mem_access, i_valid); end
    tick; mem_ready = 0; mem_data = 0; #1;
    vecs++; if (i_valid !== 1'b1 || i_rdata !== 32'h3c1d8000) begin errs++; $display("FAIL fetch_data got v=%0h d=%h exp 1 3c1d8000", i_valid, i_rdata); end
    vecs++; if (mem_access !== 1'b0 || stall_if !== 1'b0) begin errs++; $display("FAIL fetch_idle got access=%0h stall_if=%0h exp 0 0", mem_access, stall_if); end
    tick; tick; #1;
    vecs++; if (i_valid !== 1'b1 || mem_access !== 1'b0) begin errs++; $display("FAIL fetch_held got v=%0h access=%0h exp 1 0", i_valid, mem_access); end
    tick; if_advance = 1; tick; if_advance = 0; i_req = 0; #1;
    vecs++; if (i_valid !== 1'b0) begin errs++; $display("FAIL fetch_advance got %0h exp 0", i_valid); end
    tick; #1;
    vecs++; if (mem_access !== 1'b0) begin errs++; $display("FAIL fetch_noreq got %0h exp 0", mem_access); end
  endtask
  task test_conflict;
    tick; i_req = 1; i_addr = 32'hbfc00004; d_req = 1; d_write = 0; d_addr = 32'h80001000; d_size = 2'b10; d_sel = 4'hf;
    tick; #1;
    vecs++; if (mem_access !== 1'b1 || mem_a !== 32'h80001000 || mem_write !== 1'b0) begin errs++; $display("FAIL conflict_data_first got a=%h w=%0h exp 80001000 0", mem_a, mem_write); end
    tick; mem_ready = 1; mem_data = 32'h12345678; #1;
    vecs++; if (d_ready !== 1'b1 || d_rdata !== 32'h12345678 || stall_mem !== 1'b0) begin errs++; $display("FAIL conflict_dready got r=%0h d=%h s=%0h exp 1 12345678 0", d_ready, d_rdata, stall_mem); end
    tick; mem_ready = 0; mem_data = 0; #1;
    vecs++; if (d_ready !== 1'b0 || mem_access !== 1'b0) begin errs++; $display("FAIL conflict_gap got r=%0h access=%0h exp 0 0", d_ready, mem_access); end
    tick; d_req = 0; #1;
    vecs++; if (mem_access !== 1'b1 || mem_a !== 32'hbfc00004 || mem_write !== 1'b0) begin errs++; $display("FAIL conflict_fetch_second got access=%0h a=%h exp 1 bfc00004", mem_access, mem_a); end
    vecs++; if (d_ready !== 1'b0) begin errs++; $display("FAIL conflict_single_pulse got %0h exp 0", d_ready); end
    mem_ready = 1; mem_data = 32'habcd0000; tick; mem_ready = 0; #1;
    vecs++; if (i_valid !== 1'b1 || i_rdata !== 32'habcd0000) begin errs++; $display("FAIL conflict_ifetch got v=%0h d=%h exp 1 abcd0000", i_valid, i_rdata); end
    if_advance = 1; i_req = 0; tick; if_advance = 0;
  endtask
  task test_remap;
    tick; d_req = 1; d_write = 1; d_addr = 32'hbfaf8000; d_sel = 4'b0001; d_size = 2'b00; d_wdata = 32'h000000aa;
    tick; #1;
    vecs++; if (mem_a !== 32'h1faf8000) begin errs++; $display("FAIL remap_addr got %h exp 1faf8000", mem_a); end
    vecs++; if ({mem_write, mem_sel, mem_size} !== {1'b1, 4'b0001, 2'b00}) begin errs++; $display("FAIL remap_fields got %b exp 1000100", {mem_write, mem_sel, mem_size}); end
    vecs++; if (mem_st_data !== 32'h000000aa) begin errs++; $display("FAIL remap_wdata got %h exp 000000aa", mem_st_data); end
    mem_ready = 1; #1;
    vecs++; if (d_ready !== 1'b1) begin errs++; $display("FAIL remap_dready got %0h exp 1", d_ready); end
    tick; d_req = 0; mem_ready = 0; #1;
    vecs++; if (mem_access !== 1'b0) begin errs++; $display("FAIL remap_done got %0h exp 0", mem_access); end
  endtask
  task test_flush;
    tick; d_req = 1; d_write = 0; d_addr = 32'h80002000; d_size = 2'b10; d_sel = 4'hf; flush = 1;
    tick; #1;
    vecs++; if (mem_access !== 1'b0) begin errs++; $display("FAIL flush_idle_block got %0h exp 0", mem_access); end
    flush = 0; tick; #1;
    vecs++; if (mem_access !== 1'b1 || mem_a !== 32'h80002000) begin errs++; $display("FAIL flush_issue got access=%0h a=%h exp 1 80002000", mem_access, mem_a); end
    flush = 1; tick; flush = 0; d_req = 0; tick; mem_ready = 1; mem_data = 32'hdeadbeef; #1;
    vecs++; if (d_ready !== 1'b0 || d_rdata !== 32'h0) begin errs++; $display("FAIL flush_cancel got r=%0h d=%h exp 0 0", d_ready, d_rdata); end
    tick; mem_ready = 0; mem_data = 0; #1;
    vecs++; if (mem_access !== 1'b0) begin errs++; $display("FAIL flush_idle got %0h exp 0", mem_access); end
    tick; #1;
    vecs++; if (mem_access !== 1'b0 || i_valid !== 1'b0) begin errs++; $display("FAIL flush_noreissue got access=%0h v=%0h exp 0 0", mem_access, i_valid); end
  endtask
  task test_hold;
    tick; i_req = 1; i_addr = 32'hbfc00010;
    tick; mem_ready = 1; mem_data = 32'h8c880000; tick; mem_ready = 0; #1;
    vecs++; if (i_valid !== 1'b1 || i_rdata !== 32'h8c880000) begin errs++; $display("FAIL hold_fetch got v=%0h d=%h exp 1 8c880000", i_valid, i_rdata); end
    d_req = 1; d_write = 1; d_addr = 32'h80003000; d_size = 2'b10; d_sel = 4'hf; d_wdata = 32'h55;
    tick; #1;
    vecs++; if (mem_access !== 1'b1 || mem_a !== 32'h80003000 || mem_write !== 1'b1) begin errs++; $display("FAIL hold_store got access=%0h a=%h w=%0h exp 1 80003000 1", mem_access, mem_a, mem_write); end
    mem_ready = 1; #1;
    vecs++; if (d_ready !== 1'b1) begin errs++; $display("FAIL hold_store_ready got %0h exp 1", d_ready); end
    tick; d_req = 0; mem_ready = 0; tick; #1;
    vecs++; if (mem_access !== 1'b0 || i_valid !== 1'b1) begin errs++; $display("FAIL hold_nofetch got access=%0h v=%0h exp 0 1", mem_access, i_valid); end
    if_advance = 1; i_addr = 32'hbfc00014; tick; if_advance = 0; #1;
    vecs++; if (i_valid !== 1'b0 || mem_access !== 1'b0) begin errs++; $display("FAIL hold_advance got v=%0h access=%0h exp 0 0", i_valid, mem_access); end
    tick; #1;
    vecs++; if (mem_access !== 1'b1 || mem_a !== 32'hbfc00014) begin errs++; $display("FAIL hold_next_fetch got access=%0h a=%h exp 1 bfc00014", mem_access, mem_a); end
    mem_ready = 1; mem_data = 32'h11112222; tick; mem_ready = 0; i_req = 0; #1;
    vecs++; if (i_valid !== 1'b1 || i_rdata !== 32'h11112222) begin errs++; $display("FAIL hold_fetch2 got v=%0h d=%h exp 1 11112222", i_valid, i_rdata); end
    flush = 1; tick; flush = 0; #1;
    vecs++; if (i_valid !== 1'b0) begin errs++; $display("FAIL hold_flush_clear got %0h exp 0", i_valid); end
  endtask
  task test_reset_busy;
    tick; i_req = 1; i_addr = 32'hbfc00020; tick; #1;
    vecs++; if (mem_access !== 1'b1) begin errs++; $display("FAIL rstbusy_issue got %0h exp 1", mem_access); end
    resetn = 1; tick; resetn = 0; i_req = 0; #1;
    vecs++; if ({mem_access, mem_write, mem_size, mem_sel, mem_a} !== 40'h0 || i_valid !== 1'b0) begin errs++; $display("FAIL rstbusy_clear got %h v=%0h exp 0 0", {mem_access, mem_write, mem_size, mem_sel, mem_a}, i_valid); end
    mem_ready = 1; mem_data = 32'hffffffff; tick; mem_ready = 0; #1;
    vecs++; if (i_valid !== 1'b0 || i_rdata !== 32'h0 || mem_access !== 1'b0) begin errs++; $display("FAIL rstbusy_ignore got v=%0h d=%h access=%0h exp 0 0 0", i_valid, i_rdata, mem_access); end
  endtask
  initial begin
    resetn = 1; i_req = 0; i_addr = 0; if_advance = 0; d_req = 0; d_write = 0; d_size = 0; d_sel = 0;
    d_addr = 0; d_wdata = 0; flush = 0; mem_ready = 0; mem_data = 0;
    test_reset;
    test_fetch;
    test_conflict;
    test_remap;
    test_flush;
    test_hold;
    test_reset_busy;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
